// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, datapath select and control-state definitions
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // alu_op values, also consumed by the ALU function decoder
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  function automatic logic is_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_main_ctrl.sv
// rtl/mc_main_ctrl.sv - multicycle MIPS main control FSM with mem_ready stalls
module mc_main_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       pc_we,
  output logic       branch,
  output logic       iord,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_dst,
  output logic       mem2reg,
  output logic       reg_we,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state
);

  state_t state_q, state_d;

  // zero is consumed by the datapath together with branch
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (mem_ready) state_d = MEMWB;
      MEMWR:   if (mem_ready) state_d = FETCH;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      MEMWB, ALUWB, ADDIWB, BEQEX, JEX: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_we      = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    reg_dst    = 1'b0;
    mem2reg    = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    pc_src     = PCSRC_ALU;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    instr_done = 1'b0;
    unique case (state_q)
      FETCH: begin
        // rst_n gates the handshake-driven enables so reset never writes
        alu_src_b = SRCB_FOUR;
        ir_we     = mem_ready & rst_n;
        pc_we     = mem_ready & rst_n;
      end
      DECODE: begin
        alu_src_b  = SRCB_IMM_SH2;
        illegal    = !is_supported(opcode);
        instr_done = illegal;
      end
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEMRD: iord = 1'b1;
      MEMWR: begin
        iord       = 1'b1;
        mem_we     = 1'b1;
        instr_done = mem_ready;
      end
      MEMWB: begin
        mem2reg    = 1'b1;
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        reg_dst    = 1'b1;
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      ADDIWB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      BEQEX: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PCSRC_ALUOUT;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      JEX: begin
        pc_src     = PCSRC_JUMP;
        pc_we      = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb/tb_mc_main_ctrl.sv - randomized self-checking bench for mc_main_ctrl
module tb_mc_main_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       zero;
  logic       pc_we, branch, iord, mem_we, ir_we, reg_dst, mem2reg, reg_we, alu_src_a;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic       illegal, instr_done;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       pc_we, branch, iord, mem_we, ir_we, reg_dst, mem2reg, reg_we, alu_src_a;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic       illegal, instr_done;
  } outs_t;

  outs_t obs;
  assign obs = {pc_we, branch, iord, mem_we, ir_we, reg_dst, mem2reg, reg_we, alu_src_a,
                alu_src_b, pc_src, alu_op, illegal, instr_done};

  mc_main_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pc_we(pc_we), .branch(branch), .iord(iord), .mem_we(mem_we), .ir_we(ir_we),
    .reg_dst(reg_dst), .mem2reg(mem2reg), .reg_we(reg_we), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op), .illegal(illegal),
    .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic known_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Output table per state; illegal and instr_done are filled in by the caller
  function automatic outs_t exp_out(input state_t s, input logic mr);
    outs_t o = '0;
    case (s)
      FETCH:          begin o.alu_src_b = 2'b01; o.ir_we = mr; o.pc_we = mr; end
      DECODE:         o.alu_src_b = 2'b11;
      MEMADR, ADDIEX: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      MEMRD:          o.iord = 1'b1;
      MEMWR:          begin o.iord = 1'b1; o.mem_we = 1'b1; end
      MEMWB:          begin o.mem2reg = 1'b1; o.reg_we = 1'b1; end
      EXECUTE:        begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
      ALUWB:          begin o.reg_dst = 1'b1; o.reg_we = 1'b1; end
      ADDIWB:         o.reg_we = 1'b1;
      BEQEX:          begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.branch = 1'b1; end
      JEX:            begin o.pc_src = 2'b10; o.pc_we = 1'b1; end
      default:        ;
    endcase
    return o;
  endfunction

  // Expected per-cycle trace: states in order, each with the mem_ready driven that cycle
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall, input string tag);
    state_t sq[$];
    logic   mq[$];
    outs_t  e;
    for (int i = 0; i < fstall; i++) begin sq.push_back(FETCH); mq.push_back(1'b0); end
    sq.push_back(FETCH); mq.push_back(1'b1);
    sq.push_back(DECODE); mq.push_back(1'($urandom_range(0, 1)));
    case (op)
      OP_LW: begin
        sq.push_back(MEMADR); mq.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mstall; i++) begin sq.push_back(MEMRD); mq.push_back(1'b0); end
        sq.push_back(MEMRD); mq.push_back(1'b1);
        sq.push_back(MEMWB); mq.push_back(1'($urandom_range(0, 1)));
      end
      OP_SW: begin
        sq.push_back(MEMADR); mq.push_back(1'($urandom_range(0, 1)));
        for (int i = 0; i < mstall; i++) begin sq.push_back(MEMWR); mq.push_back(1'b0); end
        sq.push_back(MEMWR); mq.push_back(1'b1);
      end
      OP_RTYPE: begin
        sq.push_back(EXECUTE); mq.push_back(1'($urandom_range(0, 1)));
        sq.push_back(ALUWB);   mq.push_back(1'($urandom_range(0, 1)));
      end
      OP_ADDI: begin
        sq.push_back(ADDIEX); mq.push_back(1'($urandom_range(0, 1)));
        sq.push_back(ADDIWB); mq.push_back(1'($urandom_range(0, 1)));
      end
      OP_BEQ: begin sq.push_back(BEQEX); mq.push_back(1'($urandom_range(0, 1))); end
      OP_J:   begin sq.push_back(JEX);   mq.push_back(1'($urandom_range(0, 1))); end
      default: ;
    endcase
    for (int i = 0; i < sq.size(); i++) begin
      opcode    = op;
      mem_ready = mq[i];
      zero      = 1'($urandom_range(0, 1));
      #1;
      e            = exp_out(sq[i], mq[i]);
      e.illegal    = (sq[i] == DECODE) && !known_op(op);
      e.instr_done = (i == sq.size() - 1);
      vectors++;
      if (state !== 4'(sq[i]) || obs !== e) begin
        miscompares++;
        $display("FAIL %s cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b",
                 tag, i, state, obs, sq[i], e);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (state !== 4'(FETCH)) begin
      miscompares++;
      $display("FAIL %s end: state=%0d, expected FETCH after %0d cycles", tag, state, sq.size());
    end
  endtask

  task automatic check_reset_outs(input string tag);
    outs_t e;
    e = exp_out(FETCH, 1'b0);
    vectors++;
    if (state !== 4'(FETCH) || obs !== e) begin
      miscompares++;
      $display("FAIL %s: state=%0d outs=%b, expected state=0 outs=%b", tag, state, obs, e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_LW; zero = 1'b0;
    #3;
    check_reset_outs("reset_initial");
    @(posedge clk); #1;
    check_reset_outs("reset_held");
    rst_n = 1'b1;
  endtask

  task automatic test_lw();         run_instr(OP_LW, 0, 0, "lw");                     endtask
  task automatic test_sw_stall();   run_instr(OP_SW, 0, 3, "sw_stall3");              endtask
  task automatic test_rtype_beq();  run_instr(OP_RTYPE, 0, 0, "rtype"); run_instr(OP_BEQ, 0, 0, "beq"); endtask
  task automatic test_illegal();    run_instr(6'b111111, 0, 0, "illegal");            endtask
  task automatic test_j_fetch_stall(); run_instr(OP_J, 2, 0, "j_fstall2");            endtask

  task automatic test_async_reset();
    opcode = OP_LW;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      @(posedge clk); #1;
    end
    vectors++;
    if (state !== 4'(MEMRD)) begin
      miscompares++;
      $display("FAIL async_pre: state=%0d, expected %0d", state, MEMRD);
    end
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outs("async_immediate");
    @(posedge clk); #1;
    check_reset_outs("async_held");
    rst_n = 1'b1;
    run_instr(OP_LW, 0, 0, "post_reset_lw");
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 6))
        0: op = OP_RTYPE;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_J;
        default: begin
          op = 6'($urandom);
          while (known_op(op)) op = 6'($urandom);
        end
      endcase
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype_beq();
    test_illegal();
    test_async_reset();
    test_j_fetch_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
